// File: rtl/debug_ctrl.sv
// UART debug controller: loads instruction memory from a byte stream, runs the core, and dumps
// registers/data memory as 7-byte frames. Define DEBUG_STEP_EN to add the single-step 'S' command.
module debug_ctrl #(
  parameter int                  BUS_SIZE    = 32,
  parameter int                  DATA_BITS   = 8,
  parameter int                  IMEM_ADDR_W = 8,
  parameter logic [BUS_SIZE-1:0] HALT_INSTR  = 32'hFFFF_FFFF
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic [DATA_BITS-1:0]   i_rx_data,
  input  logic                   i_rx_done,
  output logic [DATA_BITS-1:0]   o_tx_data,
  output logic                   o_tx_start,
  input  logic                   i_tx_done,
  output logic                   o_imem_wr,
  output logic [IMEM_ADDR_W-1:0] o_imem_addr,
  output logic [BUS_SIZE-1:0]    o_imem_data,
  output logic                   o_cpu_en,
  input  logic                   i_cpu_halt,
  input  logic [BUS_SIZE-1:0]    i_pc,
  output logic [4:0]             o_dbg_addr,
  input  logic [BUS_SIZE-1:0]    i_reg_data,
  input  logic [BUS_SIZE-1:0]    i_mem_data,
  output logic                   o_busy
);

  localparam int BYTES_PER_WORD = BUS_SIZE / DATA_BITS;
  localparam int BCNT_W         = $clog2(BYTES_PER_WORD);

  localparam logic [IMEM_ADDR_W-1:0] LAST_ADDR = '1;

  localparam logic [7:0] CMD_LOAD = 8'h4C;
  localparam logic [7:0] CMD_EXEC = 8'h45;
`ifdef DEBUG_STEP_EN
  localparam logic [7:0] CMD_STEP = 8'h53;
`endif

  localparam logic [7:0] TYPE_ACK = 8'h01;
  localparam logic [7:0] TYPE_REG = 8'h02;
  localparam logic [7:0] TYPE_MEM = 8'h03;
  localparam logic [7:0] TYPE_END = 8'h04;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_ACK, S_EXEC, S_STEP, S_DUMP_REG, S_DUMP_MEM, S_DUMP_END
  } state_t;

  // Per-frame sub-sequence: optional register/memory read, then one START/WAIT pair per byte.
  typedef enum logic [2:0] {
    T_ADDR, T_LAT, T_CAP, T_START, T_WAIT
  } phase_t;

  state_t                         state;
  phase_t                         phase;
  logic [BCNT_W-1:0]              byte_cnt;
  logic [BUS_SIZE-DATA_BITS-1:0]  word_buf;
  logic [IMEM_ADDR_W-1:0]         load_addr;
  logic [4:0]                     dump_idx;
  logic [2:0]                     byte_idx;
  logic [7:0]                     f_type;
  logic [15:0]                    f_index;
  logic [31:0]                    f_data;

  logic [BUS_SIZE-1:0]            word_next;
  logic                           rx_take;
  logic                           word_done;
  logic [7:0]                     cmd;
  logic [7:0]                     frame_byte;

  // Bytes arrive LSB first, so each new byte enters at the top and older bytes shift down.
  assign word_next = {i_rx_data, word_buf};
  assign rx_take   = i_rx_done && (state == S_IDLE || state == S_LOAD);
  assign word_done = rx_take && (byte_cnt == BCNT_W'(BYTES_PER_WORD - 1));
  assign cmd       = word_next[7:0];

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    frame_byte = 8'h00;
    case (byte_idx)
      3'd0:    frame_byte = f_type;
      3'd1:    frame_byte = f_index[7:0];
      3'd2:    frame_byte = f_index[15:8];
      3'd3:    frame_byte = f_data[7:0];
      3'd4:    frame_byte = f_data[15:8];
      3'd5:    frame_byte = f_data[23:16];
      3'd6:    frame_byte = f_data[31:24];
      default: frame_byte = 8'h00;
    endcase
  end

  // NOTE: all state lives in this one block and uses non-blocking assignments only.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state       <= S_IDLE;
      phase       <= T_START;
      byte_cnt    <= '0;
      word_buf    <= '0;
      load_addr   <= '0;
      dump_idx    <= '0;
      byte_idx    <= '0;
      f_type      <= '0;
      f_index     <= '0;
      f_data      <= '0;
      o_tx_data   <= '0;
      o_tx_start  <= 1'b0;
      o_imem_wr   <= 1'b0;
      o_imem_addr <= '0;
      o_imem_data <= '0;
      o_cpu_en    <= 1'b0;
      o_dbg_addr  <= '0;
      o_busy      <= 1'b0;
    end else begin
      // NOTE: strobes default low every cycle; only the firing cycle raises them.
      o_tx_start <= 1'b0;
      o_imem_wr  <= 1'b0;

      if (rx_take) begin
        word_buf <= word_next[BUS_SIZE-1:DATA_BITS];
        byte_cnt <= word_done ? '0 : byte_cnt + 1'b1;
      end

      case (state)
        S_IDLE: begin
          if (word_done) begin
            case (cmd)
              CMD_LOAD: begin
                state     <= S_LOAD;
                load_addr <= '0;
                o_busy    <= 1'b1;
              end
              CMD_EXEC: begin
                state    <= S_EXEC;
                o_cpu_en <= 1'b1;
                o_busy   <= 1'b1;
              end
`ifdef DEBUG_STEP_EN
              CMD_STEP: begin
                o_busy <= 1'b1;
                if (i_cpu_halt) begin
                  // Core already halted: nothing to step, report state only.
                  state    <= S_DUMP_REG;
                  dump_idx <= '0;
                  phase    <= T_ADDR;
                end else begin
                  state    <= S_STEP;
                  o_cpu_en <= 1'b1;
                end
              end
`endif
              default: ;
            endcase
          end
        end

        S_LOAD: begin
          if (word_done) begin
            o_imem_wr   <= 1'b1;
            o_imem_addr <= load_addr;
            o_imem_data <= word_next;
            load_addr   <= load_addr + 1'b1;
            if (word_next == HALT_INSTR || load_addr == LAST_ADDR) begin
              state    <= S_ACK;
              phase    <= T_START;
              byte_idx <= '0;
              f_type   <= TYPE_ACK;
              f_index  <= 16'(load_addr) + 16'd1;
              f_data   <= (word_next == HALT_INSTR) ? 32'd0 : 32'd1;
            end
          end
        end

        S_EXEC: begin
          if (i_cpu_halt) begin
            o_cpu_en <= 1'b0;
            state    <= S_DUMP_REG;
            dump_idx <= '0;
            phase    <= T_ADDR;
          end
        end

`ifdef DEBUG_STEP_EN
        S_STEP: begin
          o_cpu_en <= 1'b0;
          state    <= S_DUMP_REG;
          dump_idx <= '0;
          phase    <= T_ADDR;
        end
`endif

        S_ACK, S_DUMP_REG, S_DUMP_MEM, S_DUMP_END: begin
          case (phase)
            T_ADDR: begin
              o_dbg_addr <= dump_idx;
              phase      <= T_LAT;
            end
            T_LAT: phase <= T_CAP;
            T_CAP: begin
              byte_idx <= '0;
              phase    <= T_START;
              if (state == S_DUMP_REG) begin
                f_type  <= TYPE_REG;
                f_index <= {11'd0, dump_idx};
                f_data  <= 32'(i_reg_data);
              end else if (state == S_DUMP_MEM) begin
                f_type  <= TYPE_MEM;
                f_index <= {11'd0, dump_idx};
                f_data  <= 32'(i_mem_data);
              end else begin
                f_type  <= TYPE_END;
                f_index <= '0;
                f_data  <= 32'(i_pc);
              end
            end
            T_START: begin
              o_tx_data  <= DATA_BITS'(frame_byte);
              o_tx_start <= 1'b1;
              phase      <= T_WAIT;
            end
            T_WAIT: begin
              if (i_tx_done) begin
                if (byte_idx != 3'd6) begin
                  byte_idx <= byte_idx + 3'd1;
                  phase    <= T_START;
                end else begin
                  byte_idx <= '0;
                  case (state)
                    S_DUMP_REG: begin
                      phase <= T_ADDR;
                      if (dump_idx == 5'd31) begin
                        state    <= S_DUMP_MEM;
                        dump_idx <= '0;
                      end else begin
                        dump_idx <= dump_idx + 5'd1;
                      end
                    end
                    S_DUMP_MEM: begin
                      if (dump_idx == 5'd31) begin
                        state    <= S_DUMP_END;
                        dump_idx <= '0;
                        phase    <= T_CAP;
                      end else begin
                        dump_idx <= dump_idx + 5'd1;
                        phase    <= T_ADDR;
                      end
                    end
                    default: begin
                      state  <= S_IDLE;
                      phase  <= T_START;
                      o_busy <= 1'b0;
                    end
                  endcase
                end
              end
            end
            default: phase <= T_START;
          endcase
        end

        default: begin
          state    <= S_IDLE;
          o_cpu_en <= 1'b0;
          o_busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_debug_ctrl.sv
// Randomized self-checking bench for debug_ctrl: loads, exec/dump, overflow, bad commands, reset mid-dump.
// Expected writes and frames are derived from the command rules; build with DEBUG_STEP_EN to test 'S'.
module tb_debug_ctrl;

  localparam logic [31:0] HALT     = 32'hFFFF_FFFF;
  localparam int          IMEM_N   = 256;
  localparam int          DUMP_FRS = 65;

  logic        clk      = 1'b0;
  logic        rst      = 1'b1;
  logic [7:0]  rx_data  = '0;
  logic        rx_done  = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_done  = 1'b0;
  logic        imem_wr;
  logic [7:0]  imem_addr;
  logic [31:0] imem_data;
  logic        cpu_en;
  logic        cpu_halt = 1'b0;
  logic [31:0] pc       = '0;
  logic [4:0]  dbg_addr;
  logic [31:0] reg_data = '0;
  logic [31:0] mem_data = '0;
  logic        busy;

  always #5 clk = ~clk;

  debug_ctrl #(
    .BUS_SIZE(32), .DATA_BITS(8), .IMEM_ADDR_W(8), .HALT_INSTR(32'hFFFF_FFFF)
  ) dut (
    .i_clk(clk), .i_reset(rst),
    .i_rx_data(rx_data), .i_rx_done(rx_done),
    .o_tx_data(tx_data), .o_tx_start(tx_start), .i_tx_done(tx_done),
    .o_imem_wr(imem_wr), .o_imem_addr(imem_addr), .o_imem_data(imem_data),
    .o_cpu_en(cpu_en), .i_cpu_halt(cpu_halt), .i_pc(pc),
    .o_dbg_addr(dbg_addr), .i_reg_data(reg_data), .i_mem_data(mem_data),
    .o_busy(busy)
  );

  // Register file and data memory with a one-cycle registered read port.
  logic [31:0] regs [32];
  logic [31:0] mems [32];
  always @(posedge clk) begin
    reg_data <= regs[dbg_addr];
    mem_data <= mems[dbg_addr];
  end

  logic [7:0]  tx_q [$];
  logic [39:0] wr_q [$];
  logic [31:0] ld_words [$];
  logic [55:0] exp_fr [$];
  int          en_total  = 0;
  int          proto_err = 0;
  int          n_cmp     = 0;
  int          n_err     = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Monitor plus UART transmitter model: answers each start with tx_done 1..4 cycles later.
  initial begin
    bit tx_pend  = 1'b0;
    int tx_timer = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        tx_pend  = 1'b0;
        tx_timer = 0;
        tx_done  = 1'b0;
      end else begin
        tx_done = 1'b0;
        if (tx_pend) begin
          tx_timer--;
          if (tx_timer == 0) begin
            tx_done = 1'b1;
            tx_pend = 1'b0;
          end
        end
        if (tx_start) begin
          if (tx_pend) proto_err++;
          tx_q.push_back(tx_data);
          tx_pend  = 1'b1;
          tx_timer = $urandom_range(1, 4);
        end
      end
      if (imem_wr) wr_q.push_back({imem_addr, imem_data});
      if (cpu_en) en_total++;
    end
  end

  function automatic logic [55:0] frame(input logic [7:0] t, input logic [15:0] idx,
                                        input logic [31:0] d);
    return {d, idx, t};
  endfunction

  task automatic send_byte(input logic [7:0] b);
    repeat ($urandom_range(0, 2)) @(negedge clk);
    @(negedge clk);
    rx_data = b;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  task automatic send_cmd(input logic [7:0] ch);
    logic [31:0] r;
    r = $urandom();
    send_word({r[31:8], ch});
  endtask

  task automatic wait_tx(input int base, input int nbytes, input string tag);
    int k;
    k = 0;
    while ((tx_q.size() - base < nbytes || busy) && k < 30000) begin
      @(negedge clk);
      k++;
    end
    repeat (12) @(negedge clk);
    check({tag, "_bytes"}, 64'(tx_q.size() - base), 64'(nbytes));
    check({tag, "_busy"}, 64'(busy), 64'd0);
  endtask

  task automatic compare_frames(input int base, input string tag);
    logic [55:0] got;
    foreach (exp_fr[f]) begin
      if (base + 7*f + 6 < tx_q.size()) begin
        for (int j = 0; j < 7; j++) got[8*j +: 8] = tx_q[base + 7*f + j];
        check($sformatf("%s_frame%0d", tag, f), 64'(got), 64'(exp_fr[f]));
      end
    end
  endtask

  task automatic randomize_state();
    for (int i = 0; i < 32; i++) begin
      regs[i] = $urandom();
      mems[i] = $urandom();
    end
    pc = $urandom();
  endtask

  task automatic build_dump();
    exp_fr.delete();
    for (int i = 0; i < 32; i++) exp_fr.push_back(frame(8'h02, 16'(i), regs[i]));
    for (int i = 0; i < 32; i++) exp_fr.push_back(frame(8'h03, 16'(i), mems[i]));
    exp_fr.push_back(frame(8'h04, 16'h0000, pc));
  endtask

  task automatic do_load(input string tag);
    logic [39:0] exp_wr [$];
    int   wbase, tbase, n;
    logic ovf;
    wbase = wr_q.size();
    tbase = tx_q.size();
    n     = 0;
    ovf   = 1'b0;
    foreach (ld_words[i]) begin
      exp_wr.push_back({8'(i), ld_words[i]});
      n++;
      if (ld_words[i] == HALT) break;
      if (n == IMEM_N) begin
        ovf = 1'b1;
        break;
      end
    end
    send_cmd(8'h4C);
    for (int i = 0; i < n; i++) send_word(ld_words[i]);
    wait_tx(tbase, 7, tag);
    check({tag, "_wr_count"}, 64'(wr_q.size() - wbase), 64'(n));
    for (int i = 0; i < n; i++)
      if (wbase + i < wr_q.size())
        check($sformatf("%s_wr%0d", tag, i), 64'(wr_q[wbase + i]), 64'(exp_wr[i]));
    exp_fr = {frame(8'h01, 16'(n), ovf ? 32'd1 : 32'd0)};
    compare_frames(tbase, tag);
  endtask

  task automatic do_exec(input int k, input string tag);
    int tbase, en0, cnt, guard;
    randomize_state();
    cpu_halt = 1'b0;
    tbase    = tx_q.size();
    en0      = en_total;
    send_cmd(8'h45);
    cnt   = 0;
    guard = 0;
    while (guard < k + 200) begin
      if (cpu_en) cnt++;
      if (cnt >= k) break;
      @(negedge clk);
      guard++;
    end
    cpu_halt = 1'b1;
    @(negedge clk);
    @(negedge clk);
    cpu_halt = 1'b0;
    wait_tx(tbase, 7 * DUMP_FRS, tag);
    check({tag, "_en_cycles"}, 64'(en_total - en0), 64'(k));
    build_dump();
    compare_frames(tbase, tag);
  endtask

  initial begin
    int tbase, wbase, en0, k, len;
    logic [31:0] w;
    for (int i = 0; i < 32; i++) begin
      regs[i] = '0;
      mems[i] = '0;
    end

    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_tx_data",   64'(tx_data),   64'd0);
    check("rst_tx_start",  64'(tx_start),  64'd0);
    check("rst_imem_wr",   64'(imem_wr),   64'd0);
    check("rst_imem_addr", 64'(imem_addr), 64'd0);
    check("rst_imem_data", 64'(imem_data), 64'd0);
    check("rst_cpu_en",    64'(cpu_en),    64'd0);
    check("rst_dbg_addr",  64'(dbg_addr),  64'd0);
    check("rst_busy",      64'(busy),      64'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    ld_words = {32'h20041BD3, 32'h20030055, 32'hFFFFFFFF};
    do_load("load_basic");

    do_exec(50, "exec50");

    ld_words.delete();
    for (int i = 0; i < IMEM_N; i++) begin
      w = $urandom();
      if (w == HALT) w = 32'h0;
      ld_words.push_back(w);
    end
    do_load("load_ovf");

    tbase = tx_q.size();
    wbase = wr_q.size();
    send_cmd(8'h58);
    repeat (30) @(negedge clk);
    check("badcmd_tx",   64'(tx_q.size() - tbase), 64'd0);
    check("badcmd_wr",   64'(wr_q.size() - wbase), 64'd0);
    check("badcmd_busy", 64'(busy), 64'd0);
    ld_words = {32'h20041BD3, 32'h20030055, 32'hFFFFFFFF};
    do_load("load_after_bad");

`ifdef DEBUG_STEP_EN
    randomize_state();
    tbase = tx_q.size();
    en0   = en_total;
    send_cmd(8'h53);
    wait_tx(tbase, 7 * DUMP_FRS, "step");
    check("step_en_cycles", 64'(en_total - en0), 64'd1);
    build_dump();
    compare_frames(tbase, "step");
`else
    tbase = tx_q.size();
    wbase = wr_q.size();
    en0   = en_total;
    send_cmd(8'h53);
    repeat (30) @(negedge clk);
    check("step_off_tx",   64'(tx_q.size() - tbase), 64'd0);
    check("step_off_wr",   64'(wr_q.size() - wbase), 64'd0);
    check("step_off_en",   64'(en_total - en0), 64'd0);
    check("step_off_busy", 64'(busy), 64'd0);
`endif

    for (int r = 0; r < 4; r++) begin
      len = $urandom_range(1, 12);
      ld_words.delete();
      for (int i = 0; i < len - 1; i++) begin
        w = $urandom();
        if (w == HALT) w = 32'h1;
        ld_words.push_back(w);
      end
      ld_words.push_back(HALT);
      do_load($sformatf("rand_load%0d", r));
      do_exec($urandom_range(1, 40), $sformatf("rand_exec%0d", r));
    end

    // Reset while the second byte of the first REG frame is in flight.
    randomize_state();
    tbase = tx_q.size();
    send_cmd(8'h45);
    repeat (5) @(negedge clk);
    cpu_halt = 1'b1;
    @(negedge clk);
    cpu_halt = 1'b0;
    k = 0;
    while (tx_q.size() - tbase < 2 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    check("rstmid_reached", 64'(tx_q.size() - tbase), 64'd2);
    rst = 1'b1;
    @(negedge clk);
    check("rstmid_tx_start", 64'(tx_start), 64'd0);
    check("rstmid_busy",     64'(busy),     64'd0);
    check("rstmid_cpu_en",   64'(cpu_en),   64'd0);
    check("rstmid_dbg_addr", 64'(dbg_addr), 64'd0);
    @(negedge clk);
    rst   = 1'b0;
    tbase = tx_q.size();
    repeat (20) @(negedge clk);
    check("rstmid_quiet", 64'(tx_q.size() - tbase), 64'd0);
    ld_words = {32'h20041BD3, 32'h20030055, 32'hFFFFFFFF};
    do_load("rstmid_load");

    check("tx_overlap", 64'(proto_err), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
